// File: rtl/deque_pkg.sv
// Shared word definitions for the deque slot storage (queue and stack).
package deque_pkg;
  localparam int WORD_W = 8;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/queue.sv
// Select-gated FIFO slot: circular buffer with head/tail pointers and an occupancy count.
module queue
  import deque_pkg::*;
#(
  parameter logic ADDR  = 1'b0,
  parameter int   WORDS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(WORDS):0]   count,
  input  logic                     queue_select,
  input  logic                     push,
  input  logic                     pop,
  input  word_t                    data_in,
  output word_t                    data_out
);
  localparam int PW = $clog2(WORDS);
  localparam int CW = PW + 1;

  word_t           mem [WORDS];
  logic [PW-1:0]   head, tail;
  logic            sel_q;
  logic            sel, do_push, do_pop;
  logic [CW-1:0]   count_next;

  assign sel     = (queue_select == ADDR);
  // A pop in the same cycle frees the slot a full-queue push needs.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      sel_q <= 1'b0;
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (sel) begin
      sel_q <= 1'b1;
      if (do_push) begin
        mem[tail] <= data_in;
        tail      <= tail + 1'b1;
      end
      if (do_pop) head <= head + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CW'(WORDS));
    end else begin
      sel_q <= 1'b0;
    end
  end

  assign data_out = (empty | ~sel_q) ? '0 : mem[head];
endmodule

// File: tb/tb_queue.sv
// Directed checks for the FIFO slot: table of single-cycle vectors plus select/reset sequences.
module tb_queue;
  import deque_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty, full;
  logic [2:0] count;
  logic       queue_select, push, pop;
  word_t      data_in, data_out;

  int total  = 0;
  int passed = 0;

  queue #(.ADDR(1'b0), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .empty(empty), .full(full), .count(count),
    .queue_select(queue_select), .push(push), .pop(pop),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       qs, ps, pp;
    logic [7:0] din;
    int         cnt;
    logic       emp, ful;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic qs, input logic ps, input logic pp, input logic [7:0] din,
                     input int cnt, input logic emp, input logic ful, input logic [7:0] dout);
    vec_t v;
    v = '{qs, ps, pp, din, cnt, emp, ful, dout};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input logic qs, input logic ps, input logic pp, input logic [7:0] din);
    queue_select = qs; push = ps; pop = pp; data_in = din;
    @(posedge clk);
    #1;
    queue_select = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
  endtask

  task automatic chk_all(input string nm, input int cnt, input logic emp, input logic ful,
                         input logic [7:0] dout);
    chk({nm, ".count"}, int'(count), cnt);
    chk({nm, ".empty"}, int'(empty), int'(emp));
    chk({nm, ".full"},  int'(full),  int'(ful));
    chk({nm, ".data_out"}, int'(data_out), int'(dout));
  endtask

  initial begin
    rst = 1'b1; queue_select = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset", 0, 1, 0, 8'h00);

    // qs = 0 addresses this instance (ADDR = 0)
    add(0,1,0,8'hAA, 1,0,0,8'hAA);
    add(0,0,1,8'h00, 0,1,0,8'h00);
    // FIFO order, full, ignored fifth push
    add(0,1,0,8'h11, 1,0,0,8'h11);
    add(0,1,0,8'h22, 2,0,0,8'h11);
    add(0,1,0,8'h33, 3,0,0,8'h11);
    add(0,1,0,8'h44, 4,0,1,8'h11);
    add(0,1,0,8'h55, 4,0,1,8'h11);
    add(0,0,1,8'h00, 3,0,0,8'h22);
    add(0,0,1,8'h00, 2,0,0,8'h33);
    add(0,0,1,8'h00, 1,0,0,8'h44);
    add(0,0,1,8'h00, 0,1,0,8'h00);
    // wrap-around
    add(0,1,0,8'h01, 1,0,0,8'h01);
    add(0,1,0,8'h02, 2,0,0,8'h01);
    add(0,1,0,8'h03, 3,0,0,8'h01);
    add(0,0,1,8'h00, 2,0,0,8'h02);
    add(0,0,1,8'h00, 1,0,0,8'h03);
    add(0,1,0,8'h04, 2,0,0,8'h03);
    add(0,1,0,8'h05, 3,0,0,8'h03);
    add(0,1,0,8'h06, 4,0,1,8'h03);
    add(0,0,1,8'h00, 3,0,0,8'h04);
    add(0,0,1,8'h00, 2,0,0,8'h05);
    add(0,0,1,8'h00, 1,0,0,8'h06);
    add(0,0,1,8'h00, 0,1,0,8'h00);
    // push+pop when full
    add(0,1,0,8'h01, 1,0,0,8'h01);
    add(0,1,0,8'h02, 2,0,0,8'h01);
    add(0,1,0,8'h03, 3,0,0,8'h01);
    add(0,1,0,8'h04, 4,0,1,8'h01);
    add(0,1,1,8'h99, 4,0,1,8'h02);
    add(0,0,1,8'h00, 3,0,0,8'h03);
    add(0,0,1,8'h00, 2,0,0,8'h04);
    add(0,0,1,8'h00, 1,0,0,8'h99);
    add(0,0,1,8'h00, 0,1,0,8'h00);
    // push+pop when empty, then pop-when-empty ignored
    add(0,1,1,8'h77, 1,0,0,8'h77);
    add(0,0,1,8'h00, 0,1,0,8'h00);
    add(0,0,1,8'h00, 0,1,0,8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].qs, vecs[i].ps, vecs[i].pp, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].dout);
    end

    // select gating: qs = 1 does not address this instance
    step(1,1,0,8'h5A); chk_all("unsel_push", 0, 1, 0, 8'h00);
    step(1,0,1,8'h00); chk_all("unsel_pop",  0, 1, 0, 8'h00);
    step(0,1,0,8'hBB); chk_all("sel_push",   1, 0, 0, 8'hBB);
    step(1,0,0,8'h00); chk_all("desel_idle", 1, 0, 0, 8'h00);
    step(1,1,0,8'hCC); chk_all("desel_push", 1, 0, 0, 8'h00);
    queue_select = 1'b0;
    #1;
    chk("reselect_first_cycle", int'(data_out), 0);
    @(posedge clk);
    #1;
    chk("reselect_head", int'(data_out), 8'hBB);
    step(0,0,1,8'h00); chk_all("reselect_drain", 0, 1, 0, 8'h00);

    // reset mid-operation wins over a concurrent push
    step(0,1,0,8'h01);
    step(0,1,0,8'h02);
    step(0,1,0,8'h03); chk_all("pre_reset", 3, 0, 0, 8'h01);
    rst = 1'b1;
    step(0,1,0,8'hEE);
    rst = 1'b0;
    chk_all("mid_reset", 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0,1,0,8'hA1 + 8'(i));
      chk_all($sformatf("refill%0d", i), i + 1, 0, (i == 3), 8'hA1);
    end
    for (int i = 0; i < 4; i++) begin
      step(0,0,1,8'h00);
      chk_all($sformatf("walk%0d", i), 3 - i, (i == 3), 0, (i == 3) ? 8'h00 : 8'hA2 + 8'(i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
